ysyx_220066_csr_irq: RTL and testbench
======================================

# ysyx_220066_csr_irq

Parametrised machine-mode CSR unit, successor to the single-width exception-only CSR block. It holds the M-mode trap CSRs plus mie, mip, mscratch and the mcycle/minstret counters. It arbitrates synchronous exceptions, mret and a machine-timer interrupt. It sits beside the commit stage, supplies CSR read data to the csrwork datapath, and drives the redirect (jmp/nxtpc) to the fetch stage.

## Interface
Parameters:
- XLEN, 64: CSR and data width; legal values are 32 and 64.
- MSTATUS_RST, 'ha0001800: mstatus reset value, truncated to XLEN.
- MTVEC_RST, 0: mtvec reset value.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- csr_rd_addr  in  12  read address.
- csr_rd_data  out  XLEN  combinational read data; 0 when the address is unmapped.
- csr_rd_err  out  1  read address unmapped.
- csr_wr_addr  in  12  write address.
- wen  in  1  CSR instruction write.
- in_data  in  XLEN  write data from csrwork.
- csr_wr_err  out  1  wen to an unmapped or read-only address.
- raise_intr  in  1  synchronous exception at commit.
- NO  in  XLEN  exception cause.
- pc  in  XLEN  pc of the committing instruction.
- ret  in  1  mret at commit.
- commit  in  1  an instruction retires this cycle.
- timer_irq  in  1  level machine-timer request from CLINT; asynchronous to the pipeline.
- jmp  out  1  redirect fetch.
- nxtpc  out  XLEN  redirect target.
- irq_taken  out  1  asynchronous interrupt accepted this cycle.

## Operation
- Mapped CSRs:
  - mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mip 344, mcycle B00, minstret B02.
  - mip is read-only: a wen to 344 sets csr_wr_err and writes nothing.
- mip[7] (MTIP) is the timer_irq registered through 2 flops; all other mip bits read 0.
- Interrupt pending: irq_pend = mstatus[3] & mie[7] & mip[7].
- Per-cycle event priority, highest first; only the top-priority event takes effect:
  1. raise_intr (exception) — mepc<=pc, mcause<=NO; mstatus MPP<=11, MPIE<=MIE, MIE<=0. jmp=1; nxtpc=trap target.
  2. ret — MPP<=00, MIE<=MPIE, MPIE<=1. jmp=1; nxtpc=mepc.
  3. Interrupt (irq_pend & commit) — mepc<=pc, mcause<={1'b1, (XLEN-1)'d7}; mstatus updated as for an exception. irq_taken=1; jmp=1.
  4. wen — write to the addressed CSR.
- An accepted event suppresses any concurrent wen; the suppressed write is not performed and csr_wr_err stays 0.
- Trap target for an exception is {mtvec[XLEN-1:2],2'b00}.
- mepc writes force bits [1:0] to 0.
- mcycle increments by 1 every cycle, wrapping at 2^XLEN.
- minstret increments by 1 when commit=1 and neither raise_intr nor the interrupt is taken that cycle. ret counts as retiring.
- A wen to a counter in the same cycle overrides its increment.

## Timing
- Reads and error flags are combinational from the address; CSR writes land on the next rising clk edge.
- jmp, nxtpc and irq_taken are combinational in the event cycle, from pre-edge register values.
- timer_irq to irq_pend latency: 2 cycles.
- An interrupt whose enable bit is written this cycle is first visible next cycle.
- On rst assertion, registers are cleared immediately, mid-operation included:
  - mstatus=MSTATUS_RST, mtvec=MTVEC_RST; all other CSRs and sync flops 0.
  - jmp=0, irq_taken=0, csr_wr_err=0.
- The first post-reset cycle counts in mcycle, which reads 1 one cycle after rst deasserts.

## Configuration
- YSYX_220066_CSR_VECTORED_EN defined:
  - mtvec[1:0] is writable for 00 and 01; a write of 1x stores 00.
  - For an interrupt with mode 01, nxtpc = base + 4*7 = base + 28.
  - Exceptions always target base.
- YSYX_220066_CSR_VECTORED_EN undefined: mtvec[1:0] is hard-wired to 00 and all traps target base.

## Test plan
- Reset:
  - Assert rst mid-cycle with mcycle=5 → all CSRs reset asynchronously; read 300 returns a0001800; jmp=0.
  - Read 7C0 → csr_rd_err=1, data 0.
- Exception: mtvec=80000100, mstatus.MIE=1, raise_intr with NO=11, pc=80000040 → jmp=1, nxtpc=80000100; next cycle mepc=80000040, mcause=11, MIE=0, MPIE=1, MPP=11.
- Return: mret after the exception → nxtpc=80000040; next cycle MIE=1, MPIE=1, MPP=00.
- Timer interrupt: mie=80, MIE=1, timer_irq rises → irq_taken=1 on the 2nd cycle with commit=1; mcause=8000000000000007.
  - With VECTORED_EN and mtvec=80000101 → nxtpc=8000011C.
- Priority: raise_intr, ret, irq_pend and wen to 340 in the same cycle → only the exception is applied, mscratch is unchanged, minstret does not increment.
- Counters: write mcycle=FFFFFFFFFFFFFFFF → reads 0 one cycle later (wrap); 3 commits → minstret +3; wen to 344 → csr_wr_err=1.

Source files
------------

// File: rtl/ysyx_220066_csr_irq.sv
// Machine-mode CSR unit: trap CSRs, mie/mip/mscratch, mcycle/minstret, and
// exception / mret / timer-interrupt arbitration. Optional: YSYX_220066_CSR_VECTORED_EN.
module ysyx_220066_csr_irq #(
    parameter int          XLEN        = 64,
    parameter logic [63:0] MSTATUS_RST = 64'ha0001800,
    parameter logic [63:0] MTVEC_RST   = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_rd_addr,
    output logic [XLEN-1:0] csr_rd_data,
    output logic            csr_rd_err,
    input  logic [11:0]     csr_wr_addr,
    input  logic            wen,
    input  logic [XLEN-1:0] in_data,
    output logic            csr_wr_err,
    input  logic            raise_intr,
    input  logic [XLEN-1:0] NO,
    input  logic [XLEN-1:0] pc,
    input  logic            ret,
    input  logic            commit,
    input  logic            timer_irq,
    output logic            jmp,
    output logic [XLEN-1:0] nxtpc,
    output logic            irq_taken
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;

    localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-4){1'b0}}, 3'b111};

    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mcycle;
    logic [XLEN-1:0] minstret;
    logic            timer_sync_p0;
    logic            timer_sync_p1;

    logic            irq_pend;
    logic            exc_evt;
    logic            ret_evt;
    logic            irq_evt;
    logic            csr_wen;
    logic            wr_mapped;
    logic            wr_ok;
    logic [XLEN-1:0] mip;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] irq_target;

    function automatic logic [XLEN-1:0] legal_mtvec(input logic [XLEN-1:0] v);
`ifdef YSYX_220066_CSR_VECTORED_EN
        legal_mtvec = v[1] ? (v & ~XLEN'(3)) : v;
`else
        legal_mtvec = v & ~XLEN'(3);
`endif
    endfunction

    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] v);
        align4 = v & ~XLEN'(3);
    endfunction

    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] n;
        n        = s;
        n[12:11] = 2'b11;
        n[7]     = s[3];
        n[3]     = 1'b0;
        trap_mstatus = n;
    endfunction

    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] n;
        n        = s;
        n[12:11] = 2'b00;
        n[3]     = s[7];
        n[7]     = 1'b1;
        mret_mstatus = n;
    endfunction

    function automatic logic is_mapped(input logic [11:0] a);
        case (a)
            ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
            ADDR_MCAUSE, ADDR_MIP, ADDR_MCYCLE, ADDR_MINSTRET: is_mapped = 1'b1;
            default:                                           is_mapped = 1'b0;
        endcase
    endfunction

    assign mip      = {{(XLEN-8){1'b0}}, timer_sync_p1, 7'b0};
    assign irq_pend = mstatus[3] & mie[7] & timer_sync_p1;

    // Read port: purely combinational on the address
    always_comb begin
        csr_rd_err = 1'b0;
        case (csr_rd_addr)
            ADDR_MSTATUS:  csr_rd_data = mstatus;
            ADDR_MIE:      csr_rd_data = mie;
            ADDR_MTVEC:    csr_rd_data = mtvec;
            ADDR_MSCRATCH: csr_rd_data = mscratch;
            ADDR_MEPC:     csr_rd_data = mepc;
            ADDR_MCAUSE:   csr_rd_data = mcause;
            ADDR_MIP:      csr_rd_data = mip;
            ADDR_MCYCLE:   csr_rd_data = mcycle;
            ADDR_MINSTRET: csr_rd_data = minstret;
            default: begin
                csr_rd_data = '0;
                csr_rd_err  = 1'b1;
            end
        endcase
    end

    // One event per cycle; an accepted trap or return swallows any CSR write
    always_comb begin
        exc_evt    = ~rst & raise_intr;
        ret_evt    = ~rst & ~raise_intr & ret;
        irq_evt    = ~rst & ~raise_intr & ~ret & irq_pend & commit;
        csr_wen    = ~rst & wen & ~raise_intr & ~ret & ~(irq_pend & commit);
        wr_mapped  = is_mapped(csr_wr_addr);
        wr_ok      = csr_wen & wr_mapped & (csr_wr_addr != ADDR_MIP);
        csr_wr_err = csr_wen & (~wr_mapped | (csr_wr_addr == ADDR_MIP));
    end

    assign trap_base = {mtvec[XLEN-1:2], 2'b00};
`ifdef YSYX_220066_CSR_VECTORED_EN
    assign irq_target = (mtvec[1:0] == 2'b01) ? trap_base + XLEN'(28) : trap_base;
`else
    assign irq_target = trap_base;
`endif

    always_comb begin
        jmp       = exc_evt | ret_evt | irq_evt;
        irq_taken = irq_evt;
        if (exc_evt)      nxtpc = trap_base;
        else if (ret_evt) nxtpc = mepc;
        else if (irq_evt) nxtpc = irq_target;
        else              nxtpc = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus       <= MSTATUS_RST[XLEN-1:0];
            mie           <= '0;
            mtvec         <= legal_mtvec(MTVEC_RST[XLEN-1:0]);
            mscratch      <= '0;
            mepc          <= '0;
            mcause        <= '0;
            mcycle        <= '0;
            minstret      <= '0;
            timer_sync_p0 <= 1'b0;
            timer_sync_p1 <= 1'b0;
        end else begin
            // timer_irq crosses in through two flops before it can raise mip
            timer_sync_p0 <= timer_irq;
            timer_sync_p1 <= timer_sync_p0;

            mcycle <= mcycle + XLEN'(1);
            if (commit & ~exc_evt & ~irq_evt)
                minstret <= minstret + XLEN'(1);

            if (exc_evt | irq_evt) begin
                mepc    <= align4(pc);
                mcause  <= exc_evt ? NO : IRQ_CAUSE;
                mstatus <= trap_mstatus(mstatus);
            end else if (ret_evt) begin
                mstatus <= mret_mstatus(mstatus);
            end else if (wr_ok) begin
                // Later assignment wins, so a counter write beats its increment
                case (csr_wr_addr)
                    ADDR_MSTATUS:  mstatus  <= in_data;
                    ADDR_MIE:      mie      <= in_data;
                    ADDR_MTVEC:    mtvec    <= legal_mtvec(in_data);
                    ADDR_MSCRATCH: mscratch <= in_data;
                    ADDR_MEPC:     mepc     <= align4(in_data);
                    ADDR_MCAUSE:   mcause   <= in_data;
                    ADDR_MCYCLE:   mcycle   <= in_data;
                    ADDR_MINSTRET: minstret <= in_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ysyx_220066_csr_irq.sv
// Bench for ysyx_220066_csr_irq: directed literal checks plus randomized traffic
// compared every cycle against a CSR-map model held in an associative array.
module tb_ysyx_220066_csr_irq;

    logic        clk;
    logic        rst;
    logic [11:0] csr_rd_addr;
    logic [63:0] csr_rd_data;
    logic        csr_rd_err;
    logic [11:0] csr_wr_addr;
    logic        wen;
    logic [63:0] in_data;
    logic        csr_wr_err;
    logic        raise_intr;
    logic [63:0] NO;
    logic [63:0] pc;
    logic        ret;
    logic        commit;
    logic        timer_irq;
    logic        jmp;
    logic [63:0] nxtpc;
    logic        irq_taken;

    int total = 0;
    int bad   = 0;

    ysyx_220066_csr_irq dut (
        .clk(clk), .rst(rst),
        .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data), .csr_rd_err(csr_rd_err),
        .csr_wr_addr(csr_wr_addr), .wen(wen), .in_data(in_data), .csr_wr_err(csr_wr_err),
        .raise_intr(raise_intr), .NO(NO), .pc(pc), .ret(ret), .commit(commit),
        .timer_irq(timer_irq), .jmp(jmp), .nxtpc(nxtpc), .irq_taken(irq_taken)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: no finish by time limit act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [63:0] m_csr [bit [11:0]];   // writable CSRs only; mip is derived
    bit        m_hist [$];           // timer_irq seen at recent edges, newest first

    function automatic bit m_mtip();
        return (m_hist.size() >= 2) ? m_hist[1] : 1'b0;
    endfunction

    function automatic void m_reset();
        m_csr.delete();
        m_csr[12'h300] = 64'ha0001800;
        m_csr[12'h304] = 64'd0;
        m_csr[12'h305] = 64'd0;
        m_csr[12'h340] = 64'd0;
        m_csr[12'h341] = 64'd0;
        m_csr[12'h342] = 64'd0;
        m_csr[12'hB00] = 64'd0;
        m_csr[12'hB02] = 64'd0;
        m_hist.delete();
    endfunction

    function automatic bit [63:0] m_read(input bit [11:0] a, output bit err);
        err = 1'b0;
        if (a == 12'h344) return {56'd0, m_mtip(), 7'd0};
        if (m_csr.exists(a)) return m_csr[a];
        err = 1'b1;
        return 64'd0;
    endfunction

    function automatic bit [63:0] m_legal(input bit [11:0] a, input bit [63:0] v);
        if (a == 12'h341) return v & ~64'd3;
        if (a == 12'h305) begin
`ifdef YSYX_220066_CSR_VECTORED_EN
            return v[1] ? (v & ~64'd3) : v;
`else
            return v & ~64'd3;
`endif
        end
        return v;
    endfunction

    // 0 none, 1 exception, 2 mret, 3 interrupt, 4 csr write
    function automatic int m_event();
        bit [63:0] st;
        bit [63:0] ie;
        st = m_csr[12'h300];
        ie = m_csr[12'h304];
        if (rst) return 0;
        if (raise_intr) return 1;
        if (ret) return 2;
        if (st[3] && ie[7] && m_mtip() && commit) return 3;
        if (wen) return 4;
        return 0;
    endfunction

    function automatic bit [63:0] m_target(input int ev);
        bit [63:0] tv;
        bit [63:0] base;
        tv   = m_csr[12'h305];
        base = tv & ~64'd3;
        if (ev == 2) return m_csr[12'h341];
        if (ev == 3 && tv[1:0] == 2'b01) return base + 64'd28;
        return base;
    endfunction

    function automatic void m_step();
        int        ev;
        bit [63:0] st;
        bit [63:0] nst;
        ev  = m_event();
        st  = m_csr[12'h300];
        nst = st;
        m_csr[12'hB00] = m_csr[12'hB00] + 64'd1;
        if (commit && ev != 1 && ev != 3) m_csr[12'hB02] = m_csr[12'hB02] + 64'd1;
        if (ev == 1 || ev == 3) begin
            m_csr[12'h341] = pc & ~64'd3;
            m_csr[12'h342] = (ev == 1) ? NO : 64'h8000000000000007;
            nst[12:11] = 2'b11;
            nst[7]     = st[3];
            nst[3]     = 1'b0;
            m_csr[12'h300] = nst;
        end else if (ev == 2) begin
            nst[12:11] = 2'b00;
            nst[3]     = st[7];
            nst[7]     = 1'b1;
            m_csr[12'h300] = nst;
        end else if (ev == 4 && m_csr.exists(csr_wr_addr)) begin
            m_csr[csr_wr_addr] = m_legal(csr_wr_addr, in_data);
        end
        m_hist.push_front(timer_irq);
        if (m_hist.size() > 2) void'(m_hist.pop_back());
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else     m_step();
    end

    task automatic compare_now();
        int        ev;
        bit        err;
        bit [63:0] d;
        ev = m_event();
        d  = m_read(csr_rd_addr, err);
        chk("rd_data", csr_rd_data, d);
        chk("rd_err", 64'(csr_rd_err), 64'(err));
        chk("jmp", 64'(jmp), 64'(ev >= 1 && ev <= 3));
        chk("irq_taken", 64'(irq_taken), 64'(ev == 3));
        chk("wr_err", 64'(csr_wr_err), 64'(ev == 4 && !m_csr.exists(csr_wr_addr)));
        if (ev >= 1 && ev <= 3) chk("nxtpc", nxtpc, m_target(ev));
    endtask

    always @(negedge clk) compare_now();

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 1'b0; raise_intr = 1'b0; ret = 1'b0; commit = 1'b0;
        csr_wr_addr = 12'h000; in_data = 64'd0; NO = 64'd0; pc = 64'd0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] v);
        idle();
        wen = 1'b1; csr_wr_addr = a; in_data = v;
        tick();
        idle();
    endtask

    logic [11:0] addr_pool [12];
    logic [63:0] vec_irq_pc;

    initial begin
        m_reset();
        addr_pool = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                      12'h344, 12'hB00, 12'hB02, 12'h7C0, 12'h301, 12'h000};
        rst = 1'b1; timer_irq = 1'b0; csr_rd_addr = 12'h300;
        idle();
        repeat (2) tick();
        rst = 1'b0; csr_rd_addr = 12'hB00;
        #1 chk("mcycle_first", csr_rd_data, 64'd0);
        tick();
        #1 chk("mcycle_one", csr_rd_data, 64'd1);
        repeat (4) tick();
        #1 chk("mcycle_five", csr_rd_data, 64'd5);
        // asynchronous reset mid-cycle
        rst = 1'b1; csr_rd_addr = 12'h300;
        #1 chk("rst_mstatus", csr_rd_data, 64'ha0001800);
        csr_rd_addr = 12'hB00; raise_intr = 1'b1;
        #1 chk("rst_mcycle", csr_rd_data, 64'd0);
        chk("rst_jmp", 64'(jmp), 64'd0);
        tick();
        idle(); rst = 1'b0; csr_rd_addr = 12'h7C0;
        #1 chk("unmapped_err", 64'(csr_rd_err), 64'd1);
        chk("unmapped_data", csr_rd_data, 64'd0);

        // exception
        wr(12'h305, 64'h80000100);
        wr(12'h300, 64'ha0001808);
        raise_intr = 1'b1; NO = 64'd11; pc = 64'h80000040; commit = 1'b1;
        #1 chk("exc_jmp", 64'(jmp), 64'd1);
        chk("exc_nxtpc", nxtpc, 64'h80000100);
        tick();
        idle(); csr_rd_addr = 12'h341;
        #1 chk("exc_mepc", csr_rd_data, 64'h80000040);
        csr_rd_addr = 12'h342;
        #1 chk("exc_mcause", csr_rd_data, 64'd11);
        csr_rd_addr = 12'h300;
        #1 chk("exc_mstatus", csr_rd_data, 64'ha0001880);

        // mret
        tick();
        ret = 1'b1; commit = 1'b1;
        #1 chk("ret_jmp", 64'(jmp), 64'd1);
        chk("ret_nxtpc", nxtpc, 64'h80000040);
        tick();
        idle(); csr_rd_addr = 12'h300;
        #1 chk("ret_mstatus", csr_rd_data, 64'ha0000088);

        // timer interrupt through the synchroniser
        tick();
        wr(12'h304, 64'h80);
`ifdef YSYX_220066_CSR_VECTORED_EN
        wr(12'h305, 64'h80000101);
        vec_irq_pc = 64'h8000011C;
`else
        vec_irq_pc = 64'h80000100;
`endif
        wr(12'h340, 64'h55);
        timer_irq = 1'b1; commit = 1'b1; pc = 64'h80000300;
        #1 chk("irq_c0", 64'(irq_taken), 64'd0);
        tick();
        #1 chk("irq_c1", 64'(irq_taken), 64'd0);
        tick();
        #1 chk("irq_c2", 64'(irq_taken), 64'd1);
        chk("irq_jmp", 64'(jmp), 64'd1);
        chk("irq_nxtpc", nxtpc, vec_irq_pc);
        tick();
        idle(); csr_rd_addr = 12'h342;
        #1 chk("irq_mcause", csr_rd_data, 64'h8000000000000007);
        csr_rd_addr = 12'h341;
        #1 chk("irq_mepc", csr_rd_data, 64'h80000300);
        csr_rd_addr = 12'h300;
        #1 chk("irq_mstatus", csr_rd_data, 64'ha0001880);

        // all events at once: only the exception lands
        tick();
        wr(12'hB02, 64'h10);
        wr(12'h300, 64'ha0001808);
        wen = 1'b1; csr_wr_addr = 12'h340; in_data = 64'h1234;
        raise_intr = 1'b1; ret = 1'b1; commit = 1'b1; NO = 64'd2; pc = 64'h80000400;
        #1 chk("prio_nxtpc", nxtpc, 64'h80000100);
        chk("prio_irq_taken", 64'(irq_taken), 64'd0);
        chk("prio_wr_err", 64'(csr_wr_err), 64'd0);
        tick();
        idle(); csr_rd_addr = 12'h340;
        #1 chk("prio_mscratch", csr_rd_data, 64'h55);
        csr_rd_addr = 12'h342;
        #1 chk("prio_mcause", csr_rd_data, 64'd2);
        csr_rd_addr = 12'h341;
        #1 chk("prio_mepc", csr_rd_data, 64'h80000400);
        tick();
        csr_rd_addr = 12'hB02;
        #1 chk("prio_minstret", csr_rd_data, 64'h10);

        // counters
        timer_irq = 1'b0;
        wr(12'hB00, 64'hFFFFFFFFFFFFFFFF);
        csr_rd_addr = 12'hB00;
        #1 chk("mcycle_max", csr_rd_data, 64'hFFFFFFFFFFFFFFFF);
        tick();
        #1 chk("mcycle_wrap", csr_rd_data, 64'd0);
        wr(12'hB02, 64'd0);
        commit = 1'b1;
        repeat (3) tick();
        commit = 1'b0; csr_rd_addr = 12'hB02;
        #1 chk("minstret_3", csr_rd_data, 64'd3);
        wen = 1'b1; csr_wr_addr = 12'h344; in_data = 64'hFF;
        #1 chk("wr_mip_err", 64'(csr_wr_err), 64'd1);
        csr_wr_addr = 12'h7C0;
        #1 chk("wr_unmapped_err", 64'(csr_wr_err), 64'd1);
        csr_wr_addr = 12'h340;
        #1 chk("wr_ok_err", 64'(csr_wr_err), 64'd0);
        tick();
        idle();

        // randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst         = ($urandom_range(0, 299) == 0);
            csr_rd_addr = addr_pool[$urandom_range(0, 11)];
            csr_wr_addr = addr_pool[$urandom_range(0, 11)];
            wen         = ($urandom_range(0, 2) == 0);
            in_data     = {$urandom, $urandom};
            raise_intr  = ($urandom_range(0, 15) == 0);
            NO          = {$urandom, $urandom};
            pc          = {$urandom, $urandom};
            ret         = ($urandom_range(0, 15) == 0);
            commit      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) timer_irq = ~timer_irq;
        end
        tick();
        rst = 1'b0;
        idle();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
